// File: rtl/packetizer_pkg.sv
// Shared defaults and types for the S2MM packetizer.
// Optional feature macro used by this slice: PACKETIZER_ONESHOT_EN.
package packetizer_pkg;

  localparam int unsigned PKT_DATA_WIDTH = 32;
  localparam int unsigned PKT_CNT_WIDTH  = 32;

  typedef logic [PKT_CNT_WIDTH-1:0] cnt_t;

endpackage

// File: rtl/packetizer_beat_counter.sv
// Beat counter, packet wrap and tlast compare for the S2MM packetizer.
// With PACKETIZER_ONESHOT_EN defined, one packet is emitted per config 0->nonzero re-arm.
module packetizer_beat_counter
  import packetizer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = PKT_CNT_WIDTH
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [CNT_WIDTH-1:0] config_reg,
  input  logic                 beat,
  output logic [CNT_WIDTH-1:0] counter,
  output logic                 tlast,
  output logic                 active
);

  logic                 enable;
  logic [CNT_WIDTH-1:0] cfg_m1;

  // config_reg is used live; a shrink below counter still ends the packet via >=
  always_comb begin
    enable = |config_reg;
    cfg_m1 = config_reg - CNT_WIDTH'(1);
    tlast  = enable && (counter >= cfg_m1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      counter <= '0;
    end else if (beat) begin
      counter <= tlast ? '0 : counter + CNT_WIDTH'(1);
    end
  end

`ifdef PACKETIZER_ONESHOT_EN
  logic armed;
  logic seen_zero;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      armed     <= 1'b1;
      seen_zero <= 1'b0;
    end else if (armed) begin
      seen_zero <= 1'b0;
      if (beat && tlast) begin
        armed <= 1'b0;
      end
    end else if (!enable) begin
      seen_zero <= 1'b1;
    end else if (seen_zero) begin
      armed     <= 1'b1;
      seen_zero <= 1'b0;
    end
  end

  always_comb active = enable && armed;
`else
  always_comb active = enable;
`endif

endmodule

// File: rtl/packetizer_s2mm_core.sv
// AXI-Stream pass-through that cuts a continuous stream into config_reg-word packets.
// Optional PACKETIZER_ONESHOT_EN selects one-shot packet mode in the beat counter.
module packetizer_s2mm_core
  import packetizer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PKT_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = PKT_CNT_WIDTH
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,
  output logic [DATA_WIDTH-1:0] m_axis_s2mm_tdata,
  output logic                  m_axis_s2mm_tvalid,
  input  logic                  m_axis_s2mm_tready,
  output logic                  m_axis_s2mm_tlast,
  input  logic [CNT_WIDTH-1:0]  config_reg,
  output logic [CNT_WIDTH-1:0]  counter
);

  logic active;
  logic beat;

  packetizer_beat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_beat_counter (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .config_reg (config_reg),
    .beat       (beat),
    .counter    (counter),
    .tlast      (m_axis_s2mm_tlast),
    .active     (active)
  );

  // No storage: both handshakes gate on the same qualifier so beat is shared
  always_comb begin
    m_axis_s2mm_tdata  = s_axis_data_tdata;
    m_axis_s2mm_tvalid = s_axis_data_tvalid && active;
    s_axis_data_tready = m_axis_s2mm_tready && active;
    beat               = m_axis_s2mm_tvalid && m_axis_s2mm_tready;
  end

endmodule

// File: tb/tb_packetizer_s2mm_core.sv
// Directed bench for packetizer_s2mm_core (default build) with a word scoreboard.
module tb_packetizer_s2mm_core;
  import packetizer_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  cnt_t        config_reg;
  cnt_t        counter;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] sent_q[$];
  logic        have_word = 1'b0;
  logic [31:0] m_cnt = '0;
  int          beats_in_pkt = 0;
  int          exp_len = 0;

  always #5 aclk = ~aclk;

  packetizer_s2mm_core #(
    .DATA_WIDTH (32),
    .CNT_WIDTH  (32)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .m_axis_s2mm_tdata  (m_tdata),
    .m_axis_s2mm_tvalid (m_tvalid),
    .m_axis_s2mm_tready (m_tready),
    .m_axis_s2mm_tlast  (m_tlast),
    .config_reg         (config_reg),
    .counter            (counter)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; drives one cycle and checks it.
  task automatic step(input logic v, input logic r);
    logic [31:0] w;
    logic        en;
    logic        exp_tl;
    logic        beat;
    s_tvalid = v;
    m_tready = r;
    if (v && !have_word) begin
      w = $urandom;
      s_tdata = w;
      sent_q.push_back(w);
      have_word = 1'b1;
    end
    #1;
    en     = (config_reg != 0);
    exp_tl = en && (m_cnt >= config_reg - 32'd1);
    beat   = v && r && en;
    chk("m_tvalid", m_tvalid, v && en);
    chk("s_tready", s_tready, r && en);
    chk("tlast", m_tlast, exp_tl);
    if (beat) begin
      w = sent_q.pop_front();
      have_word = 1'b0;
      chk("loop_data", m_tdata, w);
      if (m_tlast) begin
        chk("pkt_len", beats_in_pkt + 1, exp_len);
        beats_in_pkt = 0;
      end else begin
        beats_in_pkt++;
      end
      m_cnt = exp_tl ? 32'd0 : m_cnt + 32'd1;
    end else if (v) begin
      chk("hold_data", m_tdata, sent_q[0]);
    end
    @(posedge aclk);
    @(negedge aclk);
    chk("counter", counter, m_cnt);
  endtask

  initial begin
    aresetn    = 1'b0;
    config_reg = '0;
    s_tvalid   = 1'b1;
    s_tdata    = 32'hdead_beef;
    m_tready   = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    chk("rst_counter", counter, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_tlast_cfg0", m_tlast, 0);
    config_reg = 32'd1;
    #1;
    chk("rst_tlast_cfg1", m_tlast, 1);
    config_reg = 32'd0;
    @(negedge aclk);
    aresetn = 1'b1;

    // disabled: source valid but nothing moves
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    // continuous packets of 10, sink always ready
    config_reg = 32'd10;
    exp_len = 10;
    step(1'b1, 1'b1);
    chk("first_cnt", counter, 1);
    for (int i = 0; i < 24; i++) step(1'b1, 1'b1);

    // loopback with random source gaps
    for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 1)), 1'b1);

    // random sink stalls
    for (int i = 0; i < 50; i++) step(1'b1, 1'($urandom_range(0, 1)));

    // mid-packet reset at counter 4
    for (int i = 0; i < 40 && m_cnt != 32'd4; i++) step(1'b1, 1'b1);
    chk("pre_reset_cnt", counter, 4);
    s_tvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("reset_async_cnt", counter, 0);
    m_cnt = '0;
    beats_in_pkt = 0;
    @(negedge aclk);
    config_reg = 32'd0;
    aresetn = 1'b1;
    step(1'b1, 1'b1);
    config_reg = 32'd10;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1);

    // finish the current packet, then config 1: tlast every beat
    for (int i = 0; i < 20 && m_cnt != 32'd0; i++) step(1'b1, 1'b1);
    config_reg = 32'd1;
    exp_len = 1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);

    // shrink 10 -> 3 at counter 5 ends the packet on the next beat
    config_reg = 32'd10;
    exp_len = 6;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    chk("pre_shrink_cnt", counter, 5);
    config_reg = 32'd3;
    step(1'b1, 1'b1);
    chk("post_shrink_cnt", counter, 0);
    exp_len = 3;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);

    // disable mid-packet: hold, then resume the same packet
    config_reg = 32'd10;
    exp_len = 10;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    config_reg = 32'd0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    chk("hold_cnt", counter, 4);
    config_reg = 32'd10;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
